// File: rtl/move_input_conditioner_if.sv
// rtl/move_input_conditioner_if.sv - raw move buttons in, active-low move commands and busy out
interface move_input_conditioner_if;
    logic btn_right_n;
    logic btn_left_n;
    logic btn_up_n;
    logic btn_down_n;
    logic mov_right;
    logic mov_left;
    logic mov_up;
    logic mov_down;
    logic busy;

    modport master (
        output btn_right_n, btn_left_n, btn_up_n, btn_down_n,
        input  mov_right, mov_left, mov_up, mov_down, busy
    );

    modport slave (
        input  btn_right_n, btn_left_n, btn_up_n, btn_down_n,
        output mov_right, mov_left, mov_up, mov_down, busy
    );
endinterface

// File: rtl/move_input_conditioner.sv
// rtl/move_input_conditioner.sv - sync/debounce/one-shot move buttons; auto-repeat under MOVE_AUTOREPEAT_EN
module move_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 5,
    parameter int REPEAT_CYCLES   = 50
) (
    input  logic                     clk,
    input  logic                     reset,
    move_input_conditioner_if.slave  mif
);

    localparam int DW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW     = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int SETTLE = SYNC_STAGES + DEBOUNCE_CYCLES;
    localparam int SW     = $clog2(SETTLE + 1);
`ifdef MOVE_AUTOREPEAT_EN
    localparam int RW     = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_WAIT_RELEASE
    } state_t;

    // Bit order everywhere: 0 = right, 1 = left, 2 = up, 3 = down (also the priority order).
    logic [3:0] btn_raw;
    logic [3:0] db_level;
    logic [3:0] armed;
    logic [3:0] press;
    logic [3:0] win;
    logic [SW-1:0] settle_cnt;

    state_t        state;
    logic [3:0]    dir;
    logic [3:0]    mov;
    logic          busy_q;
    logic [PW-1:0] pulse_cnt;
`ifdef MOVE_AUTOREPEAT_EN
    logic [RW-1:0] rep_cnt;
`endif

    assign btn_raw = {mif.btn_down_n, mif.btn_up_n, mif.btn_left_n, mif.btn_right_n};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DW-1:0]          cnt;
        logic                   level;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q <= '1;
                cnt    <= '0;
                level  <= 1'b1;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[g]};
                if (sync_q[SYNC_STAGES-1] == level) begin
                    cnt <= '0;
                end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync_q[SYNC_STAGES-1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign db_level[g] = level;
    end

    // A button only becomes eligible after it has been seen released once the debouncers have
    // had time to reflect the post-reset button levels, so a button held through reset is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            settle_cnt <= '0;
            armed      <= '0;
        end else begin
            if (settle_cnt != SW'(SETTLE)) begin
                settle_cnt <= settle_cnt + 1'b1;
            end else begin
                armed <= armed | db_level;
            end
        end
    end

    assign press = armed & ~db_level;

    always_comb begin
        win = 4'b0000;
        if (press[0])      win = 4'b0001;
        else if (press[1]) win = 4'b0010;
        else if (press[2]) win = 4'b0100;
        else if (press[3]) win = 4'b1000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_WAIT_RELEASE;
            dir       <= 4'b0000;
            mov       <= 4'b1111;
            busy_q    <= 1'b1;
            pulse_cnt <= '0;
`ifdef MOVE_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|press) begin
                        state     <= ST_PULSE;
                        dir       <= win;
                        mov       <= ~win;
                        busy_q    <= 1'b1;
                        pulse_cnt <= '0;
                    end
                end
                ST_PULSE: begin
                    if (pulse_cnt == PW'(PULSE_CYCLES - 1)) begin
                        state <= ST_WAIT_RELEASE;
                        mov   <= 4'b1111;
`ifdef MOVE_AUTOREPEAT_EN
                        rep_cnt <= '0;
`endif
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                        mov       <= ~dir;
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (&db_level) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
`ifdef MOVE_AUTOREPEAT_EN
                    // Repeat only while the latched direction is the sole button held.
                    else if (~db_level == dir) begin
                        if (rep_cnt == RW'(REPEAT_CYCLES - 1)) begin
                            state     <= ST_PULSE;
                            mov       <= ~dir;
                            pulse_cnt <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end else begin
                        rep_cnt <= '0;
                    end
`endif
                end
                default: begin
                    state  <= ST_WAIT_RELEASE;
                    mov    <= 4'b1111;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign mif.mov_right = mov[0];
    assign mif.mov_left  = mov[1];
    assign mif.mov_up    = mov[2];
    assign mif.mov_down  = mov[3];
    assign mif.busy      = busy_q;

endmodule
